// File: rtl/dequant_ctrl_pkg.sv
// Shared types for the dequantizer control slice: table/packet layout and FSM states.
package dequant_ctrl_pkg;
    localparam int NCH    = 3;
    localparam int NUM_QT = 4;
    localparam int CHW    = $clog2(NCH + 1);
    localparam int BLKW   = 3;
    localparam int QTW    = 2;

    // [row][col] of 8-bit baseline quant values
    typedef logic [7:0][7:0][7:0] quant_table_t;

    typedef struct packed {
        quant_table_t [NUM_QT-1:0]  tab;
        logic [NCH-1:0][QTW-1:0]    map;
    } quant_packet_t;

    typedef enum logic [1:0] {LOAD, RUN, DONE} dq_state_e;
endpackage

// File: rtl/dequant_ctrl_mcu_seq.sv
// MCU component sequencer: walks blocks within a channel, channels within an MCU,
// and MCUs within a scan.
module dequant_ctrl_mcu_seq
    import dequant_ctrl_pkg::*;
#(
    parameter int MCU_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     fire,
    input  logic [CHW-1:0]           cfg_nch,
    input  logic [NCH-1:0][BLKW-1:0] cfg_nblk,
    input  logic [MCU_W-1:0]         cfg_mcu_total,
    output logic [CHW-1:0]           cur_ch,
    output logic                     mcu_boundary,
    output logic                     last_blk
);
    logic [CHW-1:0]   cur_ch_q, cur_ch_d;
    logic [BLKW-1:0]  cur_blk_q, cur_blk_d;
    logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
    logic             last_in_ch, last_ch, last_mcu;

    always_comb begin
        last_in_ch = (cur_blk_q == cfg_nblk[cur_ch_q] - BLKW'(1));
        last_ch    = (cur_ch_q == cfg_nch - CHW'(1));
        last_mcu   = (mcu_cnt_q == cfg_mcu_total - MCU_W'(1));
        cur_ch_d   = cur_ch_q;
        cur_blk_d  = cur_blk_q;
        mcu_cnt_d  = mcu_cnt_q;
        if (clear) begin
            cur_ch_d  = '0;
            cur_blk_d = '0;
            mcu_cnt_d = '0;
        end else if (fire) begin
            if (!last_in_ch) begin
                cur_blk_d = cur_blk_q + BLKW'(1);
            end else begin
                cur_blk_d = '0;
                if (last_ch) begin
                    cur_ch_d  = '0;
                    mcu_cnt_d = mcu_cnt_q + MCU_W'(1);
                end else begin
                    cur_ch_d = cur_ch_q + CHW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_ch_q  <= '0;
            cur_blk_q <= '0;
            mcu_cnt_q <= '0;
        end else begin
            cur_ch_q  <= cur_ch_d;
            cur_blk_q <= cur_blk_d;
            mcu_cnt_q <= mcu_cnt_d;
        end
    end

    assign cur_ch       = cur_ch_q;
    assign mcu_boundary = (cur_ch_q == '0) && (cur_blk_q == '0);
    assign last_blk     = last_in_ch && last_ch && last_mcu;
endmodule

// File: rtl/dequant_ctrl.sv
// Dequantizer sequencer and quant-table owner: loads tables/map, steps MCU component
// order, forwards the block handshake to the IDCT and flags scan completion.
module dequant_ctrl
    import dequant_ctrl_pkg::*;
#(
    parameter int MAXBLK = 4,
    parameter int MCU_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     qt_wr_valid,
    output logic                     qt_wr_ready,
    input  logic [1:0]               qt_wr_tab,
    input  logic [5:0]               qt_wr_idx,
    input  logic [7:0]               qt_wr_data,
    input  logic                     map_wr_en,
    input  logic [CHW-1:0]           map_wr_ch,
    input  logic [1:0]               map_wr_tab,
    input  logic                     scan_start,
    input  logic                     scan_abort,
    input  logic [CHW-1:0]           cfg_nch,
    input  logic [NCH-1:0][BLKW-1:0] cfg_nblk,
    input  logic [MCU_W-1:0]         cfg_mcu_total,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     dq_valid,
    output logic [CHW-1:0]           dq_ch,
    output quant_packet_t            quant_packet,
    input  logic                     ds_ready,
    output logic                     scan_done,
    output logic                     cfg_err,
    output logic                     err_unloaded
);
    dq_state_e                state_q, state_d;
    quant_packet_t            pkt_q, pkt_d;
    logic [NUM_QT-1:0]        loaded_q, loaded_d;
    logic                     alive_q, cfg_err_q, cfg_err_d, err_unl_q, err_unl_d;
    logic [CHW-1:0]           nch_q;
    logic [NCH-1:0][BLKW-1:0] nblk_q;
    logic [MCU_W-1:0]         total_q;
    logic                     cfg_bad, cfg_latch, seq_clear, fire, mcu_boundary, last_blk;

    dequant_ctrl_mcu_seq #(.MCU_W(MCU_W)) u_seq (
        .clk          (clk),
        .rst          (rst),
        .clear        (seq_clear),
        .fire         (fire),
        .cfg_nch      (nch_q),
        .cfg_nblk     (nblk_q),
        .cfg_mcu_total(total_q),
        .cur_ch       (dq_ch),
        .mcu_boundary (mcu_boundary),
        .last_blk     (last_blk)
    );

    always_comb begin
        cfg_bad = (cfg_nch == '0) || (cfg_nch > CHW'(NCH)) || (cfg_mcu_total == '0);
        for (int i = 0; i < NCH; i++) begin
            if ((CHW'(i) < cfg_nch) &&
                ((cfg_nblk[i] == '0) || (cfg_nblk[i] > BLKW'(MAXBLK))))
                cfg_bad = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        loaded_d    = loaded_q;
        cfg_err_d   = 1'b0;
        err_unl_d   = err_unl_q;
        cfg_latch   = 1'b0;
        seq_clear   = 1'b0;
        fire        = 1'b0;
        qt_wr_ready = 1'b0;
        in_ready    = 1'b0;
        dq_valid    = 1'b0;
        scan_done   = 1'b0;
        unique case (state_q)
            LOAD: begin
                qt_wr_ready = alive_q;
                if (map_wr_en && (map_wr_ch < CHW'(NCH)))
                    pkt_d.map[map_wr_ch] = map_wr_tab;
                if (scan_start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_latch = 1'b1;
                        seq_clear = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                // An aborting cycle consumes no block, so the handshake is held low.
                dq_valid    = in_valid && !scan_abort;
                in_ready    = ds_ready && !scan_abort;
                fire        = dq_valid && in_ready;
                qt_wr_ready = mcu_boundary && !in_valid;
                if (scan_abort) begin
                    state_d   = LOAD;
                    seq_clear = 1'b1;
                end else if (fire && last_blk) begin
                    state_d = DONE;
                end
                if (fire && !loaded_q[pkt_q.map[dq_ch]])
                    err_unl_d = 1'b1;
            end
            DONE: begin
                scan_done = !scan_abort;
                seq_clear = scan_abort;
                state_d   = LOAD;
            end
            default: state_d = LOAD;
        endcase
        if (qt_wr_valid && qt_wr_ready) begin
            pkt_d.tab[qt_wr_tab][qt_wr_idx[5:3]][qt_wr_idx[2:0]] = qt_wr_data;
            if (qt_wr_idx == 6'd63)
                loaded_d[qt_wr_tab] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= LOAD;
            alive_q   <= 1'b0;
            pkt_q     <= '0;
            loaded_q  <= '0;
            cfg_err_q <= 1'b0;
            err_unl_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alive_q   <= 1'b1;
            pkt_q     <= pkt_d;
            loaded_q  <= loaded_d;
            cfg_err_q <= cfg_err_d;
            err_unl_q <= err_unl_d;
        end
    end

    // Scan geometry only matters in RUN, so it is captured without reset.
    always_ff @(posedge clk) begin
        if (cfg_latch) begin
            nch_q   <= cfg_nch;
            nblk_q  <= cfg_nblk;
            total_q <= cfg_mcu_total;
        end
    end

    assign quant_packet = pkt_q;
    assign cfg_err      = cfg_err_q;
    assign err_unloaded = err_unl_q;
endmodule

// File: tb/tb_dequant_ctrl.sv
// Bench for dequant_ctrl: config vector table plus scoreboarded scan sequences.
module tb_dequant_ctrl;
    import dequant_ctrl_pkg::*;
    localparam int MCU_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst = 1'b0;
    logic                     qt_wr_valid = 1'b0, qt_wr_ready;
    logic [1:0]               qt_wr_tab = '0;
    logic [5:0]               qt_wr_idx = '0;
    logic [7:0]               qt_wr_data = '0;
    logic                     map_wr_en = 1'b0;
    logic [CHW-1:0]           map_wr_ch = '0;
    logic [1:0]               map_wr_tab = '0;
    logic                     scan_start = 1'b0, scan_abort = 1'b0;
    logic [CHW-1:0]           cfg_nch = '0;
    logic [NCH-1:0][BLKW-1:0] cfg_nblk = '0;
    logic [MCU_W-1:0]         cfg_mcu_total = '0;
    logic                     in_valid = 1'b0, in_ready, dq_valid;
    logic [CHW-1:0]           dq_ch;
    quant_packet_t            quant_packet;
    logic                     ds_ready = 1'b0, scan_done, cfg_err, err_unloaded;

    dequant_ctrl #(.MAXBLK(4), .MCU_W(MCU_W)) dut (
        .clk(clk), .rst(rst),
        .qt_wr_valid(qt_wr_valid), .qt_wr_ready(qt_wr_ready), .qt_wr_tab(qt_wr_tab),
        .qt_wr_idx(qt_wr_idx), .qt_wr_data(qt_wr_data),
        .map_wr_en(map_wr_en), .map_wr_ch(map_wr_ch), .map_wr_tab(map_wr_tab),
        .scan_start(scan_start), .scan_abort(scan_abort),
        .cfg_nch(cfg_nch), .cfg_nblk(cfg_nblk), .cfg_mcu_total(cfg_mcu_total),
        .in_valid(in_valid), .in_ready(in_ready), .dq_valid(dq_valid), .dq_ch(dq_ch),
        .quant_packet(quant_packet), .ds_ready(ds_ready),
        .scan_done(scan_done), .cfg_err(cfg_err), .err_unloaded(err_unloaded)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int exp_q[$];
    bit bp_mode = 1'b0;

    typedef struct {
        int nch; int nb0; int nb1; int nb2; int total; bit err;
    } cfg_vec_t;
    cfg_vec_t vecs[8];

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: every transferred block must match the oldest expected channel,
    // and a stalled block must already show that channel.
    always @(negedge clk) begin
        if (scan_done === 1'b1) done_cnt++;
        if (dq_valid === 1'b1) begin
            check("dq_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("dq_ch", dq_ch, exp_q[0]);
                if (in_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_cfg(input int nch, input int b0, input int b1, input int b2, input int tot);
        cfg_nch       = CHW'(nch);
        cfg_nblk[0]   = BLKW'(b0);
        cfg_nblk[1]   = BLKW'(b1);
        cfg_nblk[2]   = BLKW'(b2);
        cfg_mcu_total = MCU_W'(tot);
    endtask

    task automatic start_scan(input int nch, input int b0, input int b1, input int b2, input int tot);
        set_cfg(nch, b0, b1, b2, tot);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
    endtask

    task automatic send_block(input int ch);
        bit got = 1'b0;
        exp_q.push_back(ch);
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            check("in_ready_mirror", in_ready, ds_ready);
            got = in_ready;
            tick();
            if (bp_mode) ds_ready = ~ds_ready;
        end
        in_valid = 1'b0;
        if (!got) check("block_timeout", got, 1);
    endtask

    task automatic qt_write(input int t, input int idx, input int d);
        bit got = 1'b0;
        qt_wr_valid = 1'b1;
        qt_wr_tab   = 2'(t);
        qt_wr_idx   = 6'(idx);
        qt_wr_data  = 8'(d);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = qt_wr_ready;
            tick();
        end
        qt_wr_valid = 1'b0;
        if (!got) check("qt_wr_timeout", got, 1);
    endtask

    task automatic map_write(input int ch, input int t);
        map_wr_en  = 1'b1;
        map_wr_ch  = CHW'(ch);
        map_wr_tab = 2'(t);
        tick();
        map_wr_en  = 1'b0;
    endtask

    task automatic send_mcu_420();
        send_block(0); send_block(0); send_block(0); send_block(0);
        send_block(1); send_block(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_qt_wr_ready"}, qt_wr_ready, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_dq_valid"}, dq_valid, 0);
        check({tag, "_dq_ch"}, dq_ch, 0);
        check({tag, "_scan_done"}, scan_done, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_err_unloaded"}, err_unloaded, 0);
        check({tag, "_packet_zero"}, quant_packet == '0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0] = '{3, 4, 1, 1, 2, 1'b0};
        vecs[1] = '{0, 1, 1, 1, 1, 1'b1};
        vecs[2] = '{3, 0, 1, 1, 2, 1'b1};
        vecs[3] = '{1, 5, 1, 1, 1, 1'b1};
        vecs[4] = '{1, 2, 0, 0, 1, 1'b0};
        vecs[5] = '{3, 4, 1, 1, 0, 1'b1};
        vecs[6] = '{2, 1, 4, 7, 3, 1'b0};
        vecs[7] = '{2, 1, 7, 1, 3, 1'b1};

        // reset state
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("qt_ready_first_cycle", qt_wr_ready, 0);
        tick();
        @(negedge clk);
        check("qt_ready_after_reset", qt_wr_ready, 1);
        tick();

        // config validation vectors
        ds_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            set_cfg(vecs[v].nch, vecs[v].nb0, vecs[v].nb1, vecs[v].nb2, vecs[v].total);
            scan_start = 1'b1;
            tick();
            scan_start = 1'b0;
            @(negedge clk);
            check($sformatf("cfg_err[%0d]", v), cfg_err, vecs[v].err);
            check($sformatf("cfg_run_in_ready[%0d]", v), in_ready, !vecs[v].err);
            tick();
            scan_abort = 1'b1;
            @(negedge clk);
            check($sformatf("cfg_err_pulse[%0d]", v), cfg_err, 0);
            tick();
            scan_abort = 1'b0;
        end

        // load tables 0 and 1, map Y->0, Cb/Cr->1
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 64; i++) qt_write(t, i, t * 64 + i);
        map_write(0, 0); map_write(1, 1); map_write(2, 1);
        @(negedge clk);
        check("tab0_r7c7", quant_packet.tab[0][7][7], 63);
        check("tab1_r2c3", quant_packet.tab[1][2][3], 83);
        check("map2", quant_packet.map[2], 1);
        tick();

        // 4:2:0 scan, two MCUs, no backpressure
        d0 = done_cnt;
        start_scan(3, 4, 1, 1, 2);
        send_mcu_420();
        send_mcu_420();
        repeat (3) tick();
        check("s1_done_once", done_cnt, d0 + 1);
        check("s1_queue_empty", exp_q.size(), 0);
        check("s1_err_unloaded", err_unloaded, 0);
        @(negedge clk);
        check("s1_back_to_load", qt_wr_ready, 1);
        tick();

        // backpressure: ds_ready toggles every cycle
        d0 = done_cnt;
        bp_mode = 1'b1;
        start_scan(3, 4, 1, 1, 1);
        send_mcu_420();
        bp_mode = 1'b0;
        ds_ready = 1'b1;
        repeat (3) tick();
        check("s2_done_once", done_cnt, d0 + 1);
        check("s2_queue_empty", exp_q.size(), 0);

        // table write requested mid-MCU is held until the next idle MCU boundary
        d0 = done_cnt;
        start_scan(3, 4, 1, 1, 2);
        send_block(0); send_block(0);
        qt_wr_valid = 1'b1; qt_wr_tab = 2'd0; qt_wr_idx = 6'd5; qt_wr_data = 8'hA5;
        @(negedge clk);
        check("s3_hold_mid_mcu", qt_wr_ready, 0);
        tick();
        send_block(0); send_block(0); send_block(1); send_block(2);
        exp_q.push_back(0);
        in_valid = 1'b1;
        ds_ready = 1'b0;
        @(negedge clk);
        check("s3_in_valid_wins", qt_wr_ready, 0);
        tick();
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("s3_ready_at_boundary", qt_wr_ready, 1);
        check("s3_old_value", quant_packet.tab[0][0][5], 5);
        tick();
        qt_wr_valid = 1'b0;
        ds_ready = 1'b1;
        @(negedge clk);
        check("s3_new_value", quant_packet.tab[0][0][5], 8'hA5);
        tick();
        send_mcu_420();
        repeat (3) tick();
        check("s3_done_once", done_cnt, d0 + 1);

        // abort after five blocks
        d0 = done_cnt;
        start_scan(3, 4, 1, 1, 2);
        send_block(0); send_block(0); send_block(0); send_block(0); send_block(1);
        scan_abort = 1'b1;
        tick();
        scan_abort = 1'b0;
        @(negedge clk);
        check("s5_abort_load", qt_wr_ready, 1);
        check("s5_abort_ch_cleared", dq_ch, 0);
        check("s5_tab0_kept", quant_packet.tab[0][0][5], 8'hA5);
        check("s5_tab1_kept", quant_packet.tab[1][2][3], 83);
        tick();
        start_scan(3, 4, 1, 1, 1);
        send_mcu_420();
        repeat (3) tick();
        check("s5_one_done_after_abort", done_cnt, d0 + 1);
        check("s5_queue_empty", exp_q.size(), 0);

        // reset asserted mid-scan
        start_scan(3, 4, 1, 1, 2);
        send_block(0); send_block(0);
        exp_q.push_back(0);
        in_valid = 1'b1;
        ds_ready = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("midrst");
        tick();
        rst = 1'b1;
        ds_ready = 1'b1;
        @(negedge clk);
        check("midrst_qt_ready_low", qt_wr_ready, 0);
        tick();
        @(negedge clk);
        check("midrst_qt_ready_high", qt_wr_ready, 1);
        tick();

        // Cb mapped to a table that was never loaded
        for (int i = 0; i < 64; i++) qt_write(0, i, i);
        map_write(1, 3);
        start_scan(2, 1, 1, 0, 1);
        send_block(0);
        @(negedge clk);
        check("s6_y_block_ok", err_unloaded, 0);
        tick();
        send_block(1);
        @(negedge clk);
        check("s6_err_set", err_unloaded, 1);
        repeat (3) tick();
        @(negedge clk);
        check("s6_err_sticky", err_unloaded, 1);
        check("s6_queue_empty", exp_q.size(), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
